// File: rtl/alu_cond_writeback.sv
// alu_cond_writeback: condition check, NZCV flag register, skip counter and a
// 2-entry in-order FIFO feeding the register-file writeback port.
module alu_cond_writeback #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] alu_out,
    input  logic         co,
    input  logic         ovf,
    input  logic         n,
    input  logic         z,
    input  logic [3:0]   cond,
    input  logic         set_flags,
    input  logic         reg_write,
    input  logic [3:0]   rd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] wb_data,
    output logic [3:0]   wb_rd,
    output logic         wb_we,
    output logic [3:0]   flags,
    output logic [7:0]   skip_count
);

    localparam int DEPTH = 2;

    logic [3:0]   flags_reg;
    logic [7:0]   skip_reg;
    logic [1:0]   count_reg;
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [W-1:0] data_mem [DEPTH];
    logic [3:0]   rd_mem   [DEPTH];
    logic         we_mem   [DEPTH];

    logic cond_pass;
    logic push;
    logic pop;
    logic fn, fz, fc, fv;

    assign {fn, fz, fc, fv} = flags_reg;

    // Evaluate the condition code against the flags register as it stands
    // before this instruction's own update.
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = fz;
            4'b0001: cond_pass = !fz;
            4'b0010: cond_pass = fc;
            4'b0011: cond_pass = !fc;
            4'b0100: cond_pass = fn;
            4'b0101: cond_pass = !fn;
            4'b0110: cond_pass = fv;
            4'b0111: cond_pass = !fv;
            4'b1000: cond_pass = fc && !fz;
            4'b1001: cond_pass = !fc || fz;
            4'b1010: cond_pass = (fn == fv);
            4'b1011: cond_pass = (fn != fv);
            4'b1100: cond_pass = !fz && (fn == fv);
            4'b1101: cond_pass = fz || (fn != fv);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Full FIFO blocks input even if the head is being consumed this cycle.
    assign in_ready  = (count_reg != 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign wb_data    = data_mem[rd_ptr_reg];
    assign wb_rd      = rd_mem[rd_ptr_reg];
    assign wb_we      = out_valid && we_mem[rd_ptr_reg];
    assign flags      = flags_reg;
    assign skip_count = skip_reg;

    // Flag register: only a passing flag-setting instruction updates it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_reg <= 4'b0000;
        end else if (push && cond_pass && set_flags) begin
            flags_reg <= {n, z, co, ovf};
        end
    end

    // Saturating count of accepted instructions whose condition failed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_reg <= 8'd0;
        end else if (push && !cond_pass && (skip_reg != 8'hFF)) begin
            skip_reg <= skip_reg + 8'd1;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keeps the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= !wr_ptr_reg;
            if (pop)  rd_ptr_reg <= !rd_ptr_reg;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Per-entry storage; failed instructions are stored with we cleared so
    // program order through writeback is preserved.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_mem[gi] <= '0;
                rd_mem[gi]   <= 4'd0;
                we_mem[gi]   <= 1'b0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                data_mem[gi] <= alu_out;
                rd_mem[gi]   <= rd;
                we_mem[gi]   <= reg_write && cond_pass;
            end
        end
    end

endmodule

// File: doc/alu_cond_writeback.md
# alu_cond_writeback

Downstream stage of the W-bit ALU. Each cycle it takes one ALU result and its flags (CO, OVF, N, Z) and checks a 4-bit condition code against an architectural NZCV flag register. It updates that register on flag-setting instructions and queues the result, destination and qualified write enable in a 2-entry FIFO toward the register-file writeback port. It also counts condition-failed instructions.

## Interface
Parameters:
- W, 16, data width; must match the ALU W.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  ALU result and sideband valid this cycle
- in_ready  out  1  stage can accept; 1 when FIFO count < 2
- alu_out  in  W  ALU result
- co, ovf, n, z  in  1 each  ALU flags for alu_out
- cond  in  4  condition code of the instruction
- set_flags  in  1  instruction updates NZCV if its condition passes
- reg_write  in  1  instruction writes rd if its condition passes
- rd  in  4  destination register index
- out_valid  out  1  FIFO head valid
- out_ready  in  1  writeback consumes head
- wb_data  out  W  head result
- wb_rd  out  4  head destination
- wb_we  out  1  head reg_write AND cond_pass; forced 0 when out_valid=0
- flags  out  4  architectural {N,Z,C,V}
- skip_count  out  8  saturating count of condition-failed accepted instructions

## Operation
- An instruction is accepted when in_valid && in_ready.
- The condition is evaluated combinationally against the current flags register, before any update from the same instruction.
- Condition codes (N,Z,C,V from flags):
  - 0000 EQ Z; 0001 NE !Z
  - 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL pass; 1111 NV fail
- On accept with pass && set_flags, flags <= {n,z,co,ovf} at that clock edge. Otherwise flags hold.
- Every accepted instruction is pushed, pass or fail, as {alu_out, rd, reg_write&pass}. A failed instruction is pushed with we=0 so program order is preserved.
- On accept with fail, skip_count increments, saturating at 255.
- FIFO: 2 entries, in order. out_valid = (count != 0). The head drives wb_data/wb_rd/wb_we.
- Pop when out_valid && out_ready.
- Count update per cycle: push only +1; pop only -1; push and pop together, count unchanged.
- Full (count=2): in_ready=0 even if out_ready=1 in that cycle. There is no same-cycle pass-through when full.
- Empty: out_valid=0, wb_we=0. wb_data/wb_rd hold their last stored value, don't-care.
- The flags port always shows the register value. It never bypasses the same-cycle update.

## Timing
- Reset values, asynchronous: flags=0000, count=0, out_valid=0, wb_we=0, wb_data=0, wb_rd=0, skip_count=0. in_ready=1.
- Reset asserted mid-operation discards all FIFO entries and clears flags at once. No writeback is issued for discarded entries.
- Latency: an instruction accepted at edge k presents on the wb_* ports, with out_valid=1, from edge k to the cycle after edge k.
- Flag latency: an instruction accepted at edge k+1 sees the flags written at edge k. Back-to-back dependent conditions therefore need no stall.
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- A producer holding in_valid with in_ready=0 must keep all inputs stable until accepted.
- Once out_valid=1, the head stays stable until popped.

## Test plan
- Reset, then one accept: alu_out=0x1234, cond=1110, set_flags=1, reg_write=1, rd=3, n=0 z=0 co=1 ovf=0 -> next cycle out_valid=1, wb_data=0x1234, wb_rd=3, wb_we=1, flags=0010.
- Back-to-back dependency: first instruction is SUB with z=1, set_flags=1, cond=AL. Next cycle, second instruction with cond=0000 EQ, reg_write=1 -> second head wb_we=1. Repeat with cond=0001 NE -> wb_we=0, skip_count +1, flags unchanged by the failed instruction even with set_flags=1.
- Condition table sweep: drive each of the 16 flag states × 16 cond codes with reg_write=1 -> wb_we matches the table. 1111 always gives wb_we=0.
- Backpressure: hold out_ready=0 and push 3 instructions -> in_ready falls after the 2nd accept and the 3rd is held. Raise out_ready -> outputs drain in order A, B, C with no loss or duplicate.
- Simultaneous push/pop at count=1 for 10 cycles -> count stays 1, output order correct. Fail condition 300 times -> skip_count saturates at 255.
- Assert reset with 2 entries queued and flags=1111 -> out_valid=0 and flags=0000 immediately, without waiting for clk. in_ready=1 after reset is released.
